// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_pkg
// Description : Shared types and the one-bit full-adder equation used by the
//               ripple-carry adder slice.
//               Contents:
//                 bit_result_t - packed {carry, sum} result of one cell
//                 add_bit()    - full-adder truth table for one bit position
// Revision    : 1.0 - initial release
// ============================================================================
package full_adder_pkg;

    typedef struct packed {
        logic carry;
        logic sum;
    } bit_result_t;

    // Sum is the parity of the three inputs; carry is generated by A&B or
    // propagated from Cin when exactly one of A/B is set.
    function automatic bit_result_t add_bit(input logic a, input logic b, input logic cin);
        bit_result_t res;
        res.sum   = a ^ b ^ cin;
        res.carry = (a & b) | (cin & (a ^ b));
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : Purely combinational one-bit full adder cell.
// Ports       : A, B  - addend bits
//               Cin   - carry in
//               S     - sum bit
//               Cout  - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    bit_result_t cell_res;

    assign cell_res = add_bit(A, B, Cin);
    assign S        = cell_res.sum;
    assign Cout     = cell_res.carry;

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : WIDTH-bit ripple-carry adder with a single registered output
//               stage. {OutputCarry, OutputS} = InputA + InputB + InputCarry,
//               one clock of latency, one result per valid input.
// Parameters  : WIDTH       - operand width, 1..64
// Ports       : Clock       - rising-edge clock
//               Reset       - synchronous, active-high
//               InputA/B    - unsigned addends
//               InputCarry  - carry in (weight 1)
//               InputValid  - qualifies the inputs at the clock edge
//               OutputS     - registered sum
//               OutputCarry - registered carry out
//               OutputValid - one-cycle pulse per new result
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             InputCarry,
    input  logic             InputValid,
    output logic [WIDTH-1:0] OutputS,
    output logic             OutputCarry,
    output logic             OutputValid
);

    // carry_chain[i] is the carry into cell i; carry_chain[WIDTH] is carry out.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_bits;

    assign carry_chain[0] = InputCarry;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder_bit u_cell (
                .A    (InputA[i]),
                .B    (InputB[i]),
                .Cin  (carry_chain[i]),
                .S    (sum_bits[i]),
                .Cout (carry_chain[i+1])
            );
        end
    endgenerate

    // Result registers only load on a valid sample, so idle (possibly
    // undriven) inputs never disturb the held result. Reset wins over valid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            OutputS     <= '0;
            OutputCarry <= 1'b0;
            OutputValid <= 1'b0;
        end else begin
            OutputValid <= InputValid;
            if (InputValid) begin
                OutputS     <= sum_bits;
                OutputCarry <= carry_chain[WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Scoreboard bench for full_adder at WIDTH 1, 8 and 16.
//               Drivers push the expected {carry, sum} on each accepted input;
//               per-instance monitors pop and compare whenever OutputValid is
//               expected, and check the held value otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- WIDTH = 1 instance ----------------
    logic       rst1, c1, v1;
    logic [0:0] a1, b1, os1;
    logic       oc1, ov1;
    full_adder #(.WIDTH(1)) u_dut1 (
        .Clock(clk), .Reset(rst1), .InputA(a1), .InputB(b1), .InputCarry(c1),
        .InputValid(v1), .OutputS(os1), .OutputCarry(oc1), .OutputValid(ov1));

    // ---------------- WIDTH = 8 instance ----------------
    logic       rst8, c8, v8;
    logic [7:0] a8, b8, os8;
    logic       oc8, ov8;
    full_adder #(.WIDTH(8)) u_dut8 (
        .Clock(clk), .Reset(rst8), .InputA(a8), .InputB(b8), .InputCarry(c8),
        .InputValid(v8), .OutputS(os8), .OutputCarry(oc8), .OutputValid(ov8));

    // ---------------- WIDTH = 16 instance ----------------
    logic        rst16, c16, v16;
    logic [15:0] a16, b16, os16;
    logic        oc16, ov16;
    full_adder #(.WIDTH(16)) u_dut16 (
        .Clock(clk), .Reset(rst16), .InputA(a16), .InputB(b16), .InputCarry(c16),
        .InputValid(v16), .OutputS(os16), .OutputCarry(oc16), .OutputValid(ov16));

    // Expected results, zero-extended {carry, sum}
    logic [64:0] q1[$];
    logic [64:0] q8[$];
    logic [64:0] q16[$];

    task automatic check(input string nm, input logic ev, input logic av,
                         input logic [64:0] e, input logic [64:0] a);
        checks++;
        if (av !== ev || a !== e) begin
            errors++;
            $display("FAIL %s: got valid=%0b value=%h, expected valid=%0b value=%h",
                     nm, av, a, ev, e);
        end
    endtask

    // What each edge sampled, seen from the bench's own stimulus
    bit rseen1, vseen1, rseen8, vseen8, rseen16, vseen16;
    always @(posedge clk) begin
        rseen1  <= rst1  === 1'b1;  vseen1  <= (v1  === 1'b1) && (rst1  !== 1'b1);
        rseen8  <= rst8  === 1'b1;  vseen8  <= (v8  === 1'b1) && (rst8  !== 1'b1);
        rseen16 <= rst16 === 1'b1;  vseen16 <= (v16 === 1'b1) && (rst16 !== 1'b1);
    end

    bit          started1, started8, started16;
    logic [64:0] held1, held8, held16;

    always @(negedge clk) begin
        if (rseen1) begin
            started1 = 1'b1; held1 = '0; q1.delete();
            check("reset_w1", 1'b0, ov1, 65'd0, 65'({oc1, os1}));
        end else if (started1) begin
            if (vseen1 && q1.size() > 0) held1 = q1.pop_front();
            check("result_w1", vseen1, ov1, held1, 65'({oc1, os1}));
        end
    end

    always @(negedge clk) begin
        if (rseen8) begin
            started8 = 1'b1; held8 = '0; q8.delete();
            check("reset_w8", 1'b0, ov8, 65'd0, 65'({oc8, os8}));
        end else if (started8) begin
            if (vseen8 && q8.size() > 0) held8 = q8.pop_front();
            check("result_w8", vseen8, ov8, held8, 65'({oc8, os8}));
        end
    end

    always @(negedge clk) begin
        if (rseen16) begin
            started16 = 1'b1; held16 = '0; q16.delete();
            check("reset_w16", 1'b0, ov16, 65'd0, 65'({oc16, os16}));
        end else if (started16) begin
            if (vseen16 && q16.size() > 0) held16 = q16.pop_front();
            check("result_w16", vseen16, ov16, held16, 65'({oc16, os16}));
        end
    end

    // ---------------- drivers ----------------
    task automatic drv1(input logic a, input logic b, input logic c, input logic v,
                        input logic [1:0] e);
        @(posedge clk); #1;
        a1 = a; b1 = b; c1 = c; v1 = v;
        if (v) q1.push_back(65'(e));
    endtask

    task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic v, input logic r, input logic [8:0] e);
        @(posedge clk); #1;
        a8 = a; b8 = b; c8 = c; v8 = v; rst8 = r;
        if (v && !r) q8.push_back(65'(e));
    endtask

    task automatic drv16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic v);
        @(posedge clk); #1;
        a16 = a; b16 = b; c16 = c; v16 = v;
        // Reference: plain unbounded-width addition
        if (v) q16.push_back(65'(a) + 65'(b) + 65'(c));
    endtask

    task automatic drain_check(input string nm, input int n);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL %s: got %0d results never produced, expected 0", nm, n);
        end
    endtask

    // Full-adder truth table indexed by {A,B,Cin}, value {Cout,S}
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        rst1 = 1; rst8 = 1; rst16 = 1;
        v1 = 0; v8 = 0; v16 = 0;
        a1 = 0; b1 = 0; c1 = 0; a8 = 0; b8 = 0; c8 = 0; a16 = 0; b16 = 0; c16 = 0;
        repeat (2) @(posedge clk);
        #1; rst1 = 0; rst8 = 0; rst16 = 0;

        // WIDTH=1 truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            drv1(idx[2], idx[1], idx[0], 1'b1, tt[i]);
        end
        drv1(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        drv1(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

        // WIDTH=8 wrap-around, hold, and reset-vs-valid
        drv8(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 9'h1FF);
        drv8(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 9'h100);
        drv8(8'h3C, 8'h0F, 1'b0, 1'b1, 1'b0, 9'h04B);
        drv8(8'hAA, 8'h0F, 1'b0, 1'b0, 1'b0, 9'h000);
        drv8(8'hAA, 8'h55, 1'b1, 1'b0, 1'b0, 9'h000);
        drv8(8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 9'h000);
        drv8(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 9'h000);
        drv8(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 9'h003);
        drv8(8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 9'h100);
        drv8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000);

        // WIDTH=16 random vectors with random idle gaps; idle inputs are X
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk); #1;
                a16 = 'x; b16 = 'x; c16 = 1'bx; v16 = 1'b0;
            end
            drv16(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        end
        drv16(16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        drain_check("drain_w1", q1.size());
        drain_check("drain_w8", q8.size());
        drain_check("drain_w16", q16.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
